beam_combiner: RTL and testbench

BEAM_COMBINER -- requirements
Module: beam_combiner

---
 rtl/beam_combiner_if.sv | 38 +++
 rtl/beam_combiner.sv | 137 +++++++++++++
 tb/tb_beam_combiner.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/beam_combiner_if.sv
// Bundle of the four joined input streams (s00, s01, s20, s21) and the
// single combined output stream of beam_combiner.
//   sXX_axi_wvalid/wready/wdata/wlast : input beats, sample i at [i*8 +: 8]
//   m00_axi_rvalid/rready/rdata/rlast : combined output beats
// Modport slave is the combiner's view; modport master is the view of the
// environment that produces input beats and consumes output beats.
interface beam_combiner_if #(
  parameter int SDATA_WIDTH = 128,
  parameter int MDATA_WIDTH = 128
);
  logic                   s00_axi_wvalid, s01_axi_wvalid, s20_axi_wvalid, s21_axi_wvalid;
  logic                   s00_axi_wready, s01_axi_wready, s20_axi_wready, s21_axi_wready;
  logic [SDATA_WIDTH-1:0] s00_axi_wdata,  s01_axi_wdata,  s20_axi_wdata,  s21_axi_wdata;
  logic                   s00_axi_wlast,  s01_axi_wlast,  s20_axi_wlast,  s21_axi_wlast;

  logic                   m00_axi_rvalid;
  logic                   m00_axi_rready;
  logic [MDATA_WIDTH-1:0] m00_axi_rdata;
  logic                   m00_axi_rlast;

  modport slave (
    input  s00_axi_wvalid, s01_axi_wvalid, s20_axi_wvalid, s21_axi_wvalid,
    output s00_axi_wready, s01_axi_wready, s20_axi_wready, s21_axi_wready,
    input  s00_axi_wdata,  s01_axi_wdata,  s20_axi_wdata,  s21_axi_wdata,
    input  s00_axi_wlast,  s01_axi_wlast,  s20_axi_wlast,  s21_axi_wlast,
    output m00_axi_rvalid, m00_axi_rdata,  m00_axi_rlast,
    input  m00_axi_rready
  );

  modport master (
    output s00_axi_wvalid, s01_axi_wvalid, s20_axi_wvalid, s21_axi_wvalid,
    input  s00_axi_wready, s01_axi_wready, s20_axi_wready, s21_axi_wready,
    output s00_axi_wdata,  s01_axi_wdata,  s20_axi_wdata,  s21_axi_wdata,
    output s00_axi_wlast,  s01_axi_wlast,  s20_axi_wlast,  s21_axi_wlast,
    input  m00_axi_rvalid, m00_axi_rdata,  m00_axi_rlast,
    output m00_axi_rready
  );
endinterface

// File: rtl/beam_combiner.sv
// beam_combiner: joins one beat from each of four sample streams, sums the
// four samples per lane (stage 1), then scales by an arithmetic right shift
// with saturation back to sample width (stage 2, the output register).
// Ports:
//   clock               sole clock, rising edge
//   resetn              synchronous active-low reset
//   bus                 beam_combiner_if.slave: four input streams + output stream
//   scale               right-shift amount 0..3, sampled when stage 1 moves to stage 2
//   last_mismatch_count saturating count of beats whose four wlast bits disagreed
//   sat_count           saturating count of beats with at least one clamped lane
module beam_combiner #(
  parameter int SDATA_WIDTH  = 128,
  parameter int SAMPLE_WIDTH = 8,
  parameter int MDATA_WIDTH  = 128
) (
  input  logic                clock,
  input  logic                resetn,
  beam_combiner_if.slave      bus,
  input  logic [1:0]          scale,
  output logic [15:0]         last_mismatch_count,
  output logic [15:0]         sat_count
);
  localparam int LANES = SDATA_WIDTH / SAMPLE_WIDTH;
  // Sum of four samples needs two extra bits to never overflow.
  localparam int SUM_W = SAMPLE_WIDTH + 2;
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  function automatic logic signed [SUM_W-1:0] sext(input logic [SAMPLE_WIDTH-1:0] s);
    return {{(SUM_W-SAMPLE_WIDTH){s[SAMPLE_WIDTH-1]}}, s};
  endfunction

  logic                    all_valid, accept;
  logic                    s1_valid, s1_load, s1_move;
  logic                    s2_valid, s2_load, out_fire;
  logic signed [SUM_W-1:0] s1_sum [LANES];
  logic                    s1_last, s1_mismatch;
  logic [3:0]              lasts;
  logic [MDATA_WIDTH-1:0]  s2_data, s2_data_nxt;
  logic                    s2_last;
  logic                    sat_any;
  logic signed [SUM_W-1:0] shifted;

  // Elastic two-stage pipeline: a stage loads when empty or draining this cycle.
  assign out_fire  = s2_valid & bus.m00_axi_rready;
  assign s2_load   = ~s2_valid | out_fire;
  assign s1_move   = s1_valid & s2_load;
  assign s1_load   = ~s1_valid | s1_move;
  assign all_valid = bus.s00_axi_wvalid & bus.s01_axi_wvalid &
                     bus.s20_axi_wvalid & bus.s21_axi_wvalid;
  // Gating with resetn keeps every wready low while reset is asserted.
  assign accept    = resetn & all_valid & s1_load;

  // One shared ready so no channel is ever consumed on its own.
  assign bus.s00_axi_wready = accept;
  assign bus.s01_axi_wready = accept;
  assign bus.s20_axi_wready = accept;
  assign bus.s21_axi_wready = accept;

  assign lasts = {bus.s21_axi_wlast, bus.s20_axi_wlast,
                  bus.s01_axi_wlast, bus.s00_axi_wlast};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; only control state and counters are reset, the
  // wide data registers are not because valid bits qualify their contents.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= accept;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        s1_sum[i] <= sext(bus.s00_axi_wdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH])
                   + sext(bus.s01_axi_wdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH])
                   + sext(bus.s20_axi_wdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH])
                   + sext(bus.s21_axi_wdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
      end
      s1_last     <= bus.s00_axi_wlast;
      s1_mismatch <= ~((&lasts) | ~(|lasts));
    end
  end

  // Floor shift (>>> on a signed sum) followed by clamp to sample range.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    s2_data_nxt = '0;
    sat_any     = 1'b0;
    shifted     = '0;
    for (int i = 0; i < LANES; i++) begin
      shifted = s1_sum[i] >>> scale;
      if (shifted > SAT_MAX) begin
        s2_data_nxt[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = SAT_MAX[SAMPLE_WIDTH-1:0];
        sat_any = 1'b1;
      end else if (shifted < SAT_MIN) begin
        s2_data_nxt[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = SAT_MIN[SAMPLE_WIDTH-1:0];
        sat_any = 1'b1;
      end else begin
        s2_data_nxt[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = shifted[SAMPLE_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s2_valid            <= 1'b0;
      last_mismatch_count <= '0;
      sat_count           <= '0;
    end else begin
      if (s2_load) begin
        s2_valid <= s1_valid;
      end
      if (s1_move && s1_mismatch && last_mismatch_count != '1) begin
        last_mismatch_count <= last_mismatch_count + 16'd1;
      end
      if (s1_move && sat_any && sat_count != '1) begin
        sat_count <= sat_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (s1_move) begin
      s2_data <= s2_data_nxt;
      s2_last <= s1_last;
    end
  end

  assign bus.m00_axi_rvalid = s2_valid;
  assign bus.m00_axi_rdata  = s2_valid ? s2_data : '0;
  assign bus.m00_axi_rlast  = s2_valid & s2_last;
endmodule

// File: tb/tb_beam_combiner.sv
// Self-checking bench for beam_combiner: directed steps plus a randomized
// stream, compared every cycle against a transaction-level reference model
// (a queue of expected beats computed with plain integer arithmetic).
module tb_beam_combiner;
  localparam int DW = 128;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  scale;
  logic [15:0] mm_cnt, sat_cnt;

  always #5 clock = ~clock;

  beam_combiner_if #(.SDATA_WIDTH(DW), .MDATA_WIDTH(DW)) bus ();

  beam_combiner #(.SDATA_WIDTH(DW), .SAMPLE_WIDTH(8), .MDATA_WIDTH(DW)) dut (
    .clock               (clock),
    .resetn              (resetn),
    .bus                 (bus.slave),
    .scale               (scale),
    .last_mismatch_count (mm_cnt),
    .sat_count           (sat_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            mm;
    int            sat;
    int            acc_edge;
  } beat_t;

  beat_t         q[$];
  int            n_checks = 0, n_pass = 0, n_fail = 0;
  int            edge_cnt = 0, pop_mm = 0, pop_sat = 0;
  int            n_obs_acc = 0, n_obs_out = 0;
  int            stall_acc = 0, max_stall_acc = 0;
  logic [DW-1:0] last_out;
  logic          last_out_last;
  logic [DW-1:0] prev_data;
  bit            prev_stall = 1'b0;
  bit            chk_en = 1'b0;

  // Stimulus for the coming cycle.
  logic [DW-1:0] dat [4];
  logic [3:0]    lst, vld;
  logic          rdy, rst_v;
  logic [1:0]    scl;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [7:0] v);
    return {16{v}};
  endfunction

  // Expected output beat from the current input samples and scale.
  function automatic beat_t model_beat(input logic [1:0] sc);
    beat_t             b;
    logic signed [7:0] smp;
    int                s, d, v;
    b.data = '0;
    b.sat  = 0;
    d      = 1 << sc;
    for (int lane = 0; lane < 16; lane++) begin
      s = 0;
      for (int ch = 0; ch < 4; ch++) begin
        smp = dat[ch][lane*8 +: 8];
        s += int'(smp);
      end
      v = s / d;
      if ((s % d != 0) && (s < 0)) v -= 1;   // floor, not truncate
      if (v > 127)  begin v = 127;  b.sat = 1; end
      if (v < -128) begin v = -128; b.sat = 1; end
      b.data[lane*8 +: 8] = 8'(v);
    end
    b.last     = lst[0];
    b.mm       = (lst != 4'b0000 && lst != 4'b1111) ? 1 : 0;
    b.acc_edge = 0;
    return b;
  endfunction

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic cycle();
    bit    vis, exp_rdy;
    beat_t hd, nb;
    resetn             = rst_v;
    scale              = scl;
    bus.s00_axi_wvalid = vld[0]; bus.s01_axi_wvalid = vld[1];
    bus.s20_axi_wvalid = vld[2]; bus.s21_axi_wvalid = vld[3];
    bus.s00_axi_wdata  = dat[0]; bus.s01_axi_wdata  = dat[1];
    bus.s20_axi_wdata  = dat[2]; bus.s21_axi_wdata  = dat[3];
    bus.s00_axi_wlast  = lst[0]; bus.s01_axi_wlast  = lst[1];
    bus.s20_axi_wlast  = lst[2]; bus.s21_axi_wlast  = lst[3];
    bus.m00_axi_rready = rdy;
    #1;
    // Oldest held beat is visible once at least one edge has passed since acceptance.
    vis     = (q.size() > 0) && (q[0].acc_edge < edge_cnt);
    // Capacity of two beats, one slot freed by a same-cycle output handshake.
    exp_rdy = rst_v && (&vld) && ((q.size() < 2) || (vis && rdy));
    if (vis) hd = q[0];
    if (chk_en) begin
      check("rvalid",  bus.m00_axi_rvalid, vis);
      check("rdata",   bus.m00_axi_rdata,  vis ? hd.data : '0);
      check("rlast",   bus.m00_axi_rlast,  vis ? hd.last : 1'b0);
      check("wready00", bus.s00_axi_wready, exp_rdy);
      check("wready01", bus.s01_axi_wready, exp_rdy);
      check("wready20", bus.s20_axi_wready, exp_rdy);
      check("wready21", bus.s21_axi_wready, exp_rdy);
      check("mm_count",  mm_cnt,  16'(pop_mm  + (vis ? hd.mm  : 0)));
      check("sat_count", sat_cnt, 16'(pop_sat + (vis ? hd.sat : 0)));
      if (prev_stall) check("stall_stable", bus.m00_axi_rdata, prev_data);
    end
    if (bus.s00_axi_wready && (&vld)) n_obs_acc++;
    if (bus.m00_axi_rvalid && rdy)    n_obs_out++;
    if (!rdy) begin
      if (bus.s00_axi_wready && (&vld)) stall_acc++;
      if (stall_acc > max_stall_acc) max_stall_acc = stall_acc;
    end else begin
      stall_acc = 0;
    end
    prev_stall = vis && !rdy && rst_v;
    prev_data  = bus.m00_axi_rdata;
    if (rst_v) begin
      if (vis && rdy) begin
        void'(q.pop_front());
        pop_mm  += hd.mm;
        pop_sat += hd.sat;
        last_out      = hd.data;
        last_out_last = hd.last;
      end
      if (exp_rdy) begin
        nb          = model_beat(scl);
        nb.acc_edge = edge_cnt + 1;
        q.push_back(nb);
      end
    end
    @(posedge clock);
    edge_cnt++;
    if (!rst_v) begin
      q.delete();
      pop_mm    = 0;
      pop_sat   = 0;
      stall_acc = 0;
    end
    #1;
  endtask

  // Send one beat with rready high, then idle until it has drained.
  task automatic send_one();
    vld = 4'hF; rdy = 1'b1;
    cycle();
    vld = 4'h0;
    repeat (3) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acc, base_out;
    for (int c = 0; c < 4; c++) dat[c] = '0;
    lst = 4'h0; vld = 4'hF; rdy = 1'b1; scl = 2'd0; rst_v = 1'b0;
    resetn = 1'b0;

    // Reset with all inputs valid: nothing may be accepted.
    cycle();
    chk_en = 1'b1;
    cycle();
    rst_v = 1'b1;
    vld   = 4'h0;
    cycle();

    // Basic sum: 10 + 20 - 5 + 3 = 28, scale 0.
    dat[0] = fill(8'd10); dat[1] = fill(8'd20); dat[2] = fill(8'hFB); dat[3] = fill(8'd3);
    scl = 2'd0;
    send_one();
    check("r033_data", last_out, fill(8'd28));
    check("r033_sat",  sat_cnt, 16'd0);

    // Saturation high, then scaled down to fit.
    for (int c = 0; c < 4; c++) dat[c] = fill(8'd127);
    scl = 2'd0;
    send_one();
    check("r034_sat_hi_data",  last_out, fill(8'd127));
    check("r034_sat_hi_count", sat_cnt, 16'd1);
    scl = 2'd2;
    send_one();
    check("r034_sc2_data",  last_out, fill(8'd127));
    check("r034_sc2_count", sat_cnt, 16'd1);
    for (int c = 0; c < 4; c++) dat[c] = fill(8'h80);
    send_one();
    check("r034_neg_data", last_out, fill(8'h80));
    dat[0] = fill(8'hFF); dat[1] = '0; dat[2] = '0; dat[3] = '0;
    scl = 2'd1;
    send_one();
    check("r034_floor_data", last_out, fill(8'hFF));

    // Mismatched wlast (s00,s01,s20,s21 = 1,1,0,1).
    scl = 2'd0;
    lst = 4'b1011;
    send_one();
    check("r037_rlast", last_out_last, 1'b1);
    check("r037_mm1",   mm_cnt, 16'd1);
    lst = 4'b1111;
    send_one();
    lst = 4'b0000;
    send_one();
    check("r037_mm_hold", mm_cnt, 16'd1);

    // One channel missing: nothing consumed until it arrives.
    dat[0] = fill(8'd1); dat[1] = fill(8'd2); dat[2] = fill(8'd3); dat[3] = fill(8'd4);
    base_acc = n_obs_acc; base_out = n_obs_out;
    vld = 4'b0111; rdy = 1'b1;
    repeat (5) cycle();
    check("r035_none_taken", 32'(n_obs_acc - base_acc), 32'd0);
    vld = 4'hF;
    cycle();
    vld = 4'h0;
    repeat (3) cycle();
    check("r035_one_in",  32'(n_obs_acc - base_acc), 32'd1);
    check("r035_one_out", 32'(n_obs_out - base_out), 32'd1);

    // Randomized 20-beat stream with random back-pressure.
    scl = 2'($urandom_range(0, 3));
    base_acc = n_obs_acc; base_out = n_obs_out;
    max_stall_acc = 0; stall_acc = 0;
    for (int cyc = 0; cyc < 400 && (n_obs_acc - base_acc) < 20; cyc++) begin
      for (int c = 0; c < 4; c++) dat[c] = {$urandom, $urandom, $urandom, $urandom};
      lst = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ($urandom_range(0, 1) ? 4'hF : 4'h0);
      vld = ($urandom_range(0, 9) < 8) ? 4'hF : 4'($urandom);
      rdy = 1'($urandom_range(0, 1));
      cycle();
    end
    check("r036_accepted", 32'(n_obs_acc - base_acc), 32'd20);
    vld = 4'h0; rdy = 1'b1;
    repeat (4) cycle();
    check("r036_delivered", 32'(n_obs_out - base_out), 32'd20);
    check("r036_stall_cap", 1'(max_stall_acc <= 2), 1'b1);

    // Reset with both stages full and output stalled.
    scl = 2'd0;
    lst = 4'b0001;
    dat[0] = fill(8'd5); dat[1] = fill(8'd5); dat[2] = fill(8'd5); dat[3] = fill(8'd5);
    vld = 4'hF; rdy = 1'b0;
    repeat (3) cycle();
    rst_v = 1'b0;
    cycle();
    rst_v = 1'b1;
    check("r038_rvalid", bus.m00_axi_rvalid, 1'b0);
    check("r038_mm",     mm_cnt,  16'd0);
    check("r038_sat",    sat_cnt, 16'd0);
    lst = 4'b0000; rdy = 1'b1;
    dat[0] = fill(8'd1); dat[1] = fill(8'd2); dat[2] = fill(8'd3); dat[3] = fill(8'd4);
    cycle();
    vld = 4'h0;
    cycle();
    check("r038_new_valid", bus.m00_axi_rvalid, 1'b1);
    check("r038_new_data",  bus.m00_axi_rdata, fill(8'd10));
    repeat (2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
